// File: rtl/top_vending_machine.sv
`default_nettype none
// ============================================================================
// Module   : top_vending_machine
// Brief    : Coin-operated drink dispenser. Coffee costs 1 unit and sprite
//            costs 3 units. The machine holds up to 3 units of credit and
//            shows the credit on a 7-segment display. Every output is
//            registered and decodes from the machine state.
// Revision : 1.0  initial release
// ============================================================================
module top_vending_machine (
  input  logic       clk,
  input  logic       rst_n,        // synchronous, active-high despite the name
  input  logic       i_coin,
  input  logic       i_coffee,
  input  logic       i_sprite,
  output logic       o_led_coffee,
  output logic       o_led_sprite,
  output logic       o_coffee,
  output logic       o_sprite,
  output logic [7:0] o_seg
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_COIN_1       = 3'd1,
    S_COIN_2       = 3'd2,
    S_COIN_3       = 3'd3,
    S_COFFEE_OUT_1 = 3'd4,
    S_COFFEE_OUT_2 = 3'd5,
    S_COFFEE_OUT_3 = 3'd6,
    S_SPRITE_OUT_3 = 3'd7
  } state_t;

  // 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;

  state_t     state_q, state_d;
  logic       coin_q, coffee_q, sprite_q;
  logic       coin_evt, coffee_evt, sprite_evt;
  logic       led_coffee_q, led_coffee_d;
  logic       led_sprite_q, led_sprite_d;
  logic       coffee_out_q, coffee_out_d;
  logic       sprite_out_q, sprite_out_d;
  logic [7:0] seg_q, seg_d;

  // Rising-edge detection against last cycle's sampled inputs
  always_comb begin
    coin_evt   = i_coin   & ~coin_q;
    coffee_evt = i_coffee & ~coffee_q;
    sprite_evt = i_sprite & ~sprite_q;
  end

  // Next state: sprite beats coffee beats coin; OUT states ignore events
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (coin_evt) state_d = S_COIN_1;
      end
      S_COIN_1: begin
        if (coffee_evt)    state_d = S_COFFEE_OUT_1;
        else if (coin_evt) state_d = S_COIN_2;
      end
      S_COIN_2: begin
        if (coffee_evt)    state_d = S_COFFEE_OUT_2;
        else if (coin_evt) state_d = S_COIN_3;
      end
      S_COIN_3: begin
        if (sprite_evt)      state_d = S_SPRITE_OUT_3;
        else if (coffee_evt) state_d = S_COFFEE_OUT_3;
      end
      S_COFFEE_OUT_1: state_d = S_IDLE;
      S_COFFEE_OUT_2: state_d = S_COIN_1;
      S_COFFEE_OUT_3: state_d = S_COIN_2;
      S_SPRITE_OUT_3: state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs track state_q
  always_comb begin
    led_coffee_d = 1'b0;
    led_sprite_d = 1'b0;
    coffee_out_d = 1'b0;
    sprite_out_d = 1'b0;
    seg_d        = SEG_0;
    case (state_d)
      S_IDLE:         seg_d = SEG_0;
      S_COIN_1: begin
        led_coffee_d = 1'b1;
        seg_d        = SEG_1;
      end
      S_COIN_2: begin
        led_coffee_d = 1'b1;
        seg_d        = SEG_2;
      end
      S_COIN_3: begin
        led_coffee_d = 1'b1;
        led_sprite_d = 1'b1;
        seg_d        = SEG_3;
      end
      S_COFFEE_OUT_1: begin
        coffee_out_d = 1'b1;
        seg_d        = SEG_0;
      end
      S_COFFEE_OUT_2: begin
        coffee_out_d = 1'b1;
        seg_d        = SEG_1;
      end
      S_COFFEE_OUT_3: begin
        coffee_out_d = 1'b1;
        seg_d        = SEG_2;
      end
      S_SPRITE_OUT_3: begin
        sprite_out_d = 1'b1;
        seg_d        = SEG_0;
      end
      default:        seg_d = SEG_0;
    endcase
  end

  // State, input history and registered outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      coin_q       <= 1'b0;
      coffee_q     <= 1'b0;
      sprite_q     <= 1'b0;
      led_coffee_q <= 1'b0;
      led_sprite_q <= 1'b0;
      coffee_out_q <= 1'b0;
      sprite_out_q <= 1'b0;
      seg_q        <= SEG_0;
    end else begin
      state_q      <= state_d;
      coin_q       <= i_coin;
      coffee_q     <= i_coffee;
      sprite_q     <= i_sprite;
      led_coffee_q <= led_coffee_d;
      led_sprite_q <= led_sprite_d;
      coffee_out_q <= coffee_out_d;
      sprite_out_q <= sprite_out_d;
      seg_q        <= seg_d;
    end
  end

  assign o_led_coffee = led_coffee_q;
  assign o_led_sprite = led_sprite_q;
  assign o_coffee     = coffee_out_q;
  assign o_sprite     = sprite_out_q;
  assign o_seg        = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_top_vending_machine.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_vending_machine
// Brief    : Scoreboard bench for top_vending_machine. A credit-counting
//            reference model predicts the outputs after every clock edge;
//            a monitor pops and compares them after each rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_top_vending_machine;

  logic       clk;
  logic       rst_n;
  logic       i_coin, i_coffee, i_sprite;
  logic       o_led_coffee, o_led_sprite, o_coffee, o_sprite;
  logic [7:0] o_seg;

  typedef struct packed {
    logic       coffee;
    logic       sprite;
    logic       led_coffee;
    logic       led_sprite;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   drain_done = 0;

  // Reference model state: credit, previous input levels, "just dispensed"
  int   credit = 0;
  bit   p_coin = 0, p_coffee = 0, p_sprite = 0;
  bit   dispensing = 0;
  logic [7:0] seg_tab [4];

  top_vending_machine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_coin       (i_coin),
    .i_coffee     (i_coffee),
    .i_sprite     (i_sprite),
    .o_led_coffee (o_led_coffee),
    .o_led_sprite (o_led_sprite),
    .o_coffee     (o_coffee),
    .o_sprite     (o_sprite),
    .o_seg        (o_seg)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  // Drive one cycle of inputs, predict the outputs after the next rising edge
  task automatic step(input bit r, input bit c, input bit cf, input bit sp);
    exp_t e;
    bit ec, ecf, esp, pulse_c, pulse_s;
    rst_n = r; i_coin = c; i_coffee = cf; i_sprite = sp;
    pulse_c = 0; pulse_s = 0;
    if (r) begin
      credit = 0; p_coin = 0; p_coffee = 0; p_sprite = 0; dispensing = 0;
    end else begin
      ec  = c  && !p_coin;
      ecf = cf && !p_coffee;
      esp = sp && !p_sprite;
      p_coin = c; p_coffee = cf; p_sprite = sp;
      if (dispensing) begin
        dispensing = 0;
      end else if (esp && credit == 3) begin
        credit = 0; pulse_s = 1; dispensing = 1;
      end else if (ecf && credit >= 1) begin
        credit = credit - 1; pulse_c = 1; dispensing = 1;
      end else if (ec && credit < 3) begin
        credit = credit + 1;
      end
    end
    e.coffee     = pulse_c;
    e.sprite     = pulse_s;
    e.led_coffee = !dispensing && credit >= 1;
    e.led_sprite = !dispensing && credit == 3;
    e.seg        = seg_tab[credit];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("o_coffee",     int'(o_coffee),     int'(e.coffee));
        chk("o_sprite",     int'(o_sprite),     int'(e.sprite));
        chk("o_led_coffee", int'(o_led_coffee), int'(e.led_coffee));
        chk("o_led_sprite", int'(o_led_sprite), int'(e.led_sprite));
        chk("o_seg",        int'(o_seg),        int'(e.seg));
      end
    end
  end

  initial begin
    seg_tab[0] = 8'h3F; seg_tab[1] = 8'h06; seg_tab[2] = 8'h5B; seg_tab[3] = 8'h4F;
    // Reset held for two edges
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    idle_n(1);
    // One coin then coffee
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); idle_n(2);
    // Two coins then coffee: credit 1 remains
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); idle_n(2);
    // From credit 1: two coins to credit 3, coffee leaves 2
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); idle_n(2);
    // From credit 2: coin then sprite
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 1); idle_n(2);
    // Ignored: coffee and sprite in IDLE
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    // Coin held high 5 cycles counts once
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    // Sprite at credit 2 ignored
    step(0, 0, 0, 1); step(0, 0, 0, 0);
    // Third coin, then a fourth is ignored
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    // Coin+sprite together at credit 3 -> sprite wins
    step(0, 1, 0, 1); idle_n(2);
    // Coffee+coin at credit 1 -> coffee wins
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 0); idle_n(2);
    // Reset during COIN_2
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0); idle_n(1);
    // Reset during a dispense pulse
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(1, 0, 0, 0); idle_n(1);
    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 20));
    end
    idle_n(2);
    // Let the monitor drain the last expectation
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    drain_done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard stop in case the stimulus process never reaches its end
  initial begin
    #2000000;
    if (!drain_done) begin
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/top_vending_machine.md
TOP_VENDING_MACHINE -- requirements
Module: top_vending_machine

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high; ports are named clk and rst_n as in the codebase, and rst_n resets the block when driven to 1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  synchronous reset; resets the block when 1 at a clk rising edge.
REQ-004 i_coin  input  1  coin insert request; each rising edge of this input (0 then 1) adds one unit of credit.
REQ-005 i_coffee  input  1  coffee select request; acts on its rising edge.
REQ-006 i_sprite  input  1  sprite select request; acts on its rising edge.
REQ-007 o_led_coffee  output  1  coffee available: 1 when credit >= 1.
REQ-008 o_led_sprite  output  1  sprite available: 1 when credit = 3.
REQ-009 o_coffee  output  1  coffee dispense pulse.
REQ-010 o_sprite  output  1  sprite dispense pulse.
REQ-011 o_seg  output  8  7-segment pattern for the displayed credit; bit order {dp,g,f,e,d,c,b,a}; a segment is lit when its bit is 1; dp is always 0.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE (credit 0), COIN_1, COIN_2, COIN_3, COFFEE_OUT_1, COFFEE_OUT_2, COFFEE_OUT_3 and SPRITE_OUT_3; all outputs SHALL decode from the current state only.
REQ-013 Prices: coffee = 1 unit, sprite = 3 units; maximum credit = 3; unspent credit is kept.
REQ-014 Edge detect: the block registers each input every cycle; an event = input is 1 now and the registered value is 0; a level held high SHALL count only once; events add no extra latency.
REQ-015 Coin events: IDLE->COIN_1, COIN_1->COIN_2, COIN_2->COIN_3; in COIN_3 a coin event is ignored (no change).
REQ-016 Coffee event in COIN_n (n=1..3) SHALL go to COFFEE_OUT_n; a coffee event in IDLE is ignored.
REQ-017 Sprite event in COIN_3 SHALL go to SPRITE_OUT_3; a sprite event in IDLE, COIN_1 or COIN_2 is ignored.
REQ-018 Priority for simultaneous events: sprite (if valid) > coffee (if valid) > coin.
REQ-019 COFFEE_OUT_n SHALL last exactly one cycle and then go to the state for credit n-1 (COFFEE_OUT_1->IDLE); SPRITE_OUT_3 SHALL last one cycle and then go to IDLE; input events in OUT states are ignored.
REQ-020 o_coffee SHALL be 1 only in the COFFEE_OUT_* states, and o_sprite SHALL be 1 only in SPRITE_OUT_3; each is therefore a one-cycle pulse beginning at the edge that samples the request.
REQ-021 o_led_coffee SHALL be 1 in COIN_1..COIN_3, and o_led_sprite SHALL be 1 in COIN_3; both SHALL be 0 in IDLE and in all OUT states.
REQ-022 o_seg SHALL show the credit held in COIN_n and IDLE; in OUT states it SHALL show the remaining credit (COFFEE_OUT_n shows n-1, SPRITE_OUT_3 shows 0).
REQ-023 o_seg encodings: 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F.

Reset
REQ-024 When rst_n=1 at a clk edge, the block SHALL enter IDLE and clear the edge-detect registers to 0, overriding all other inputs.
REQ-025 Values after reset: o_coffee=0, o_sprite=0, o_led_coffee=0, o_led_sprite=0, o_seg=0x3F.
REQ-026 Reset mid-operation, including in an OUT state, SHALL discard the credit and abort any dispense pulse on the next edge.

Verification
REQ-027 Reset, then one 1-cycle coin, then coffee -> COIN_1 (o_seg=0x06, o_led_coffee=1); o_coffee=1 for one cycle; then IDLE with o_seg=0x3F.
REQ-028 From IDLE, 2 coins then coffee -> o_seg 0x06 then 0x5B; o_coffee pulse; credit 1 remains (o_seg=0x06).
REQ-029 From credit 1, 2 coins then coffee -> second coin reaches COIN_3 (o_led_sprite=1, o_seg=0x4F); COFFEE_OUT_3 pulse; credit 2 (0x5B).
REQ-030 From credit 2, coin then sprite -> COIN_3; o_sprite=1 for one cycle; then IDLE with o_seg=0x3F and both LEDs 0.
REQ-031 Ignored events: coffee or sprite in IDLE, sprite at credit 2, a 4th coin at credit 3, and i_coin held high for 5 cycles (counts once) -> credit changes only as specified and no dispense pulse occurs.
REQ-032 Priority and reset: coin+sprite together at credit 3 -> SPRITE_OUT_3; rst_n=1 during COIN_2 -> IDLE on the next edge with o_seg=0x3F.
